// File: rtl/mem_block_responder.sv
// Block-read responder: queued block reads served from a resettable backing store; write-backs land immediately.
// Latency: RD_LATENCY cycles from dequeue to axi_rd_valid; write-back is committed on the cycle of axi_wr_rq.
// Backpressure: reads queue in a REQ_FIFO_DEPTH FIFO (overflow drops and sets sticky rq_overflow); response held until ack.
// Optional build macro MEM_RESP_PERF_EN: enables saturating rd_cnt/wr_cnt counters (tied to 0 otherwise).

// Generic FIFO used for the read-request queue.
// Latency: pop_dat shows the head combinationally; push visible one cycle later.
// Backpressure: push ignored when full, pop ignored when empty; simultaneous push/pop both take effect.
module mem_block_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             mmu_clk,
  input  logic             i_rstn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_dat,
  output logic             empty,
  output logic             full
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W:0]   wr_ptr_q;
  logic [PTR_W:0]   rd_ptr_q;
  logic [WIDTH-1:0] store_q [DEPTH];

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  always_ff @(posedge mmu_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push && !full) wr_ptr_q <= wr_ptr_q + (PTR_W+1)'(1);
      if (pop && !empty) rd_ptr_q <= rd_ptr_q + (PTR_W+1)'(1);
    end
  end

  // Entry storage needs no reset: nothing reads it while the queue is empty.
  always_ff @(posedge mmu_clk) begin
    if (push && !full) store_q[wr_ptr_q[PTR_W-1:0]] <= push_dat;
  end

  assign pop_dat = store_q[rd_ptr_q[PTR_W-1:0]];
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
endmodule

// Top: request queue, IDLE/WAIT/RESP read engine, block memory and optional counters.
// Latency: response valid RD_LATENCY cycles after dequeue; at least one idle cycle between responses.
// Backpressure: response held stable until axi_rd_valid_ack; queue absorbs reads meanwhile.
module mem_block_responder #(
  parameter int NUM_WORDS_IN_BLOCK = 4,
  parameter int MEM_BLOCKS         = 64,
  parameter int RD_LATENCY         = 4,
  parameter int REQ_FIFO_DEPTH     = 4
) (
  input  logic                            mmu_clk,
  input  logic                            i_rstn,
  input  logic                            axi_rd_rq,
  input  logic [31:0]                     axi_rd_addr,
  output logic [NUM_WORDS_IN_BLOCK*32-1:0] axi_rd_data,
  output logic                            axi_rd_valid,
  output logic [31:0]                     axi_rd_valid_addr,
  input  logic                            axi_rd_valid_ack,
  input  logic                            axi_wr_rq,
  input  logic [31:0]                     axi_wr_addr,
  input  logic [NUM_WORDS_IN_BLOCK*32-1:0] axi_wr_data,
  output logic                            rq_overflow,
  output logic                            busy,
  output logic [15:0]                     rd_cnt,
  output logic [15:0]                     wr_cnt
);
  localparam int BLK_W = NUM_WORDS_IN_BLOCK * 32;
  localparam int OFF_W = $clog2(16 * NUM_WORDS_IN_BLOCK);
  localparam int IDX_W = $clog2(MEM_BLOCKS);
  localparam int TAG_W = 32 - OFF_W;
  localparam int CNT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic               fifo_push;
  logic               fifo_pop;
  logic               fifo_empty;
  logic               fifo_full;
  logic [TAG_W-1:0]   fifo_head;
  logic               capture;
  logic [CNT_W-1:0]   lat_cnt_q;
  logic [TAG_W-1:0]   pend_tag_q;
  logic [IDX_W-1:0]   rd_idx;
  logic [IDX_W-1:0]   wr_idx;
  logic [BLK_W-1:0]   rd_blk;
  logic [BLK_W-1:0]   mem_q [MEM_BLOCKS];
  logic               unused_addr_bits;

  // Offset bits are irrelevant to a block store, and upper write-address bits alias.
  assign unused_addr_bits = ^{axi_rd_addr[OFF_W-1:0],
                              axi_wr_addr[31:OFF_W+IDX_W],
                              axi_wr_addr[OFF_W-1:0]};

  // Only the block tag is queued; the offset is zero in every response address.
  assign fifo_push = axi_rd_rq && !fifo_full;

  mem_block_fifo #(
    .WIDTH (TAG_W),
    .DEPTH (REQ_FIFO_DEPTH)
  ) u_req_fifo (
    .mmu_clk  (mmu_clk),
    .i_rstn   (i_rstn),
    .push     (fifo_push),
    .push_dat (axi_rd_addr[31:OFF_W]),
    .pop      (fifo_pop),
    .pop_dat  (fifo_head),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

  assign rd_idx = pend_tag_q[IDX_W-1:0];
  assign wr_idx = axi_wr_addr[OFF_W +: IDX_W];

  // Write-first bypass: a write-back landing on the capture cycle wins over stored data.
  assign rd_blk = (axi_wr_rq && (wr_idx == rd_idx)) ? axi_wr_data : mem_q[rd_idx];

  // FSM state register.
  always_ff @(posedge mmu_clk or negedge i_rstn) begin
    if (!i_rstn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state decode plus the dequeue and capture strobes.
  always_comb begin
    state_d  = state_q;
    fifo_pop = 1'b0;
    capture  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = WAIT;
        end
      end
      WAIT: begin
        if (lat_cnt_q == '0) begin
          capture = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (axi_rd_valid_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Latency countdown and the in-flight request tag.
  always_ff @(posedge mmu_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      lat_cnt_q  <= '0;
      pend_tag_q <= '0;
    end else if (fifo_pop) begin
      lat_cnt_q  <= CNT_W'(RD_LATENCY - 1);
      pend_tag_q <= fifo_head;
    end else if ((state_q == WAIT) && (lat_cnt_q != '0)) begin
      lat_cnt_q  <= lat_cnt_q - CNT_W'(1);
    end
  end

  // Response registers: loaded once at capture and held through RESP regardless of later writes.
  always_ff @(posedge mmu_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      axi_rd_data       <= '0;
      axi_rd_valid_addr <= '0;
    end else if (capture) begin
      axi_rd_data       <= rd_blk;
      axi_rd_valid_addr <= {pend_tag_q, {OFF_W{1'b0}}};
    end
  end

  // Backing store: write-back accepted in any state; whole array clears on reset.
  always_ff @(posedge mmu_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      for (int i = 0; i < MEM_BLOCKS; i++) mem_q[i] <= '0;
    end else if (axi_wr_rq) begin
      mem_q[wr_idx] <= axi_wr_data;
    end
  end

  // Sticky drop flag: set by any read arriving against a full queue.
  always_ff @(posedge mmu_clk or negedge i_rstn) begin
    if (!i_rstn)                    rq_overflow <= 1'b0;
    else if (axi_rd_rq && fifo_full) rq_overflow <= 1'b1;
  end

  assign axi_rd_valid = (state_q == RESP);
  assign busy         = !fifo_empty || (state_q != IDLE);

`ifdef MEM_RESP_PERF_EN
  // Saturating served-read counter: one count per accepted ack.
  always_ff @(posedge mmu_clk or negedge i_rstn) begin
    if (!i_rstn) rd_cnt <= '0;
    else if ((state_q == RESP) && axi_rd_valid_ack && (rd_cnt != 16'hFFFF))
      rd_cnt <= rd_cnt + 16'd1;
  end

  // Saturating write-back counter.
  always_ff @(posedge mmu_clk or negedge i_rstn) begin
    if (!i_rstn) wr_cnt <= '0;
    else if (axi_wr_rq && (wr_cnt != 16'hFFFF))
      wr_cnt <= wr_cnt + 16'd1;
  end
`else
  assign rd_cnt = '0;
  assign wr_cnt = '0;
`endif
endmodule

// File: tb/tb_mem_block_responder.sv
// Self-checking bench for mem_block_responder: directed scenarios plus randomized read/write traffic
// checked against a block-array reference model and per-request timing rules.
module tb_mem_block_responder;
  localparam int NW    = 4;
  localparam int BW    = NW * 32;
  localparam int NBLK  = 64;
  localparam int LAT   = 4;
  localparam int OFFB  = $clog2(16 * NW);
  localparam int IDXB  = $clog2(NBLK);
`ifdef MEM_RESP_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic          mmu_clk;
  logic          i_rstn;
  logic          axi_rd_rq;
  logic [31:0]   axi_rd_addr;
  logic [BW-1:0] axi_rd_data;
  logic          axi_rd_valid;
  logic [31:0]   axi_rd_valid_addr;
  logic          axi_rd_valid_ack;
  logic          axi_wr_rq;
  logic [31:0]   axi_wr_addr;
  logic [BW-1:0] axi_wr_data;
  logic          rq_overflow;
  logic          busy;
  logic [15:0]   rd_cnt;
  logic [15:0]   wr_cnt;

  int checks = 0;
  int errors = 0;
  int exp_rd = 0;
  int exp_wr = 0;
  logic [BW-1:0] ref_mem [NBLK];

  mem_block_responder dut (
    .mmu_clk           (mmu_clk),
    .i_rstn            (i_rstn),
    .axi_rd_rq         (axi_rd_rq),
    .axi_rd_addr       (axi_rd_addr),
    .axi_rd_data       (axi_rd_data),
    .axi_rd_valid      (axi_rd_valid),
    .axi_rd_valid_addr (axi_rd_valid_addr),
    .axi_rd_valid_ack  (axi_rd_valid_ack),
    .axi_wr_rq         (axi_wr_rq),
    .axi_wr_addr       (axi_wr_addr),
    .axi_wr_data       (axi_wr_data),
    .rq_overflow       (rq_overflow),
    .busy              (busy),
    .rd_cnt            (rd_cnt),
    .wr_cnt            (wr_cnt)
  );

  initial mmu_clk = 1'b0;
  always #5 mmu_clk = ~mmu_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog");
  end

  function automatic int idx_of(input logic [31:0] a);
    return int'(a[OFFB +: IDXB]);
  endfunction

  function automatic logic [31:0] blk_addr(input logic [31:0] a);
    return a & ~((32'd1 << OFFB) - 32'd1);
  endfunction

  function automatic logic [15:0] exp_cnt(input int n);
    if (!PERF) return 16'd0;
    return (n > 65535) ? 16'hFFFF : 16'(n);
  endfunction

  function automatic logic [BW-1:0] rand_blk();
    logic [BW-1:0] b;
    for (int i = 0; i < NW; i++) b[32*i +: 32] = $urandom;
    return b;
  endfunction

  task automatic tick();
    @(posedge mmu_clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NBLK; i++) ref_mem[i] = '0;
    exp_rd = 0;
    exp_wr = 0;
  endtask

  task automatic write_blk(input logic [31:0] addr, input logic [BW-1:0] data);
    axi_wr_rq = 1'b1; axi_wr_addr = addr; axi_wr_data = data;
    tick();
    axi_wr_rq = 1'b0;
    ref_mem[idx_of(addr)] = data;
    exp_wr++;
  endtask

  // Single read from an idle block: timing, data, address, hold stability and drop after ack.
  task automatic read_and_check(input logic [31:0] addr, input int hold, input string name);
    logic [BW-1:0] ed;
    logic [31:0]   ea;
    ed = ref_mem[idx_of(addr)];
    ea = blk_addr(addr);
    axi_rd_rq = 1'b1; axi_rd_addr = addr;
    tick();
    axi_rd_rq = 1'b0;
    repeat (LAT) tick();
    checks++;
    if (axi_rd_valid !== 1'b0) begin errors++; $display("FAIL %s_early_valid: got %b required 0", name, axi_rd_valid); end
    tick();
    checks++;
    if (axi_rd_valid !== 1'b1) begin errors++; $display("FAIL %s_valid: got %b required 1", name, axi_rd_valid); end
    checks++;
    if (axi_rd_data !== ed) begin errors++; $display("FAIL %s_data: got %h required %h", name, axi_rd_data, ed); end
    checks++;
    if (axi_rd_valid_addr !== ea) begin errors++; $display("FAIL %s_addr: got %h required %h", name, axi_rd_valid_addr, ea); end
    repeat (hold) begin
      tick();
      checks++;
      if (axi_rd_valid !== 1'b1 || axi_rd_data !== ed || axi_rd_valid_addr !== ea) begin
        errors++;
        $display("FAIL %s_hold: got v=%b a=%h required v=1 a=%h", name, axi_rd_valid, axi_rd_valid_addr, ea);
      end
    end
    axi_rd_valid_ack = 1'b1;
    tick();
    axi_rd_valid_ack = 1'b0;
    exp_rd++;
    checks++;
    if (axi_rd_valid !== 1'b0) begin errors++; $display("FAIL %s_drop: got %b required 0", name, axi_rd_valid); end
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (axi_rd_valid !== 1'b0 || busy !== 1'b0 || rq_overflow !== 1'b0) begin
      errors++; $display("FAIL reset_flags: got v=%b busy=%b ovf=%b required 0 0 0", axi_rd_valid, busy, rq_overflow);
    end
    checks++;
    if (axi_rd_data !== '0 || axi_rd_valid_addr !== 32'd0) begin
      errors++; $display("FAIL reset_regs: got d=%h a=%h required 0", axi_rd_data, axi_rd_valid_addr);
    end
    checks++;
    if (rd_cnt !== 16'd0 || wr_cnt !== 16'd0) begin
      errors++; $display("FAIL reset_cnt: got rd=%0d wr=%0d required 0 0", rd_cnt, wr_cnt);
    end
    #1 i_rstn = 1'b1;
    model_reset();
    tick();
  endtask

  task automatic test_basic();
    logic [BW-1:0] d;
    d = {32'd4, 32'd3, 32'd2, 32'd1};
    write_blk(32'h0000_0040, d);
    read_and_check(32'h0000_0040, 0, "basic");
    // Ack presented while the request is still in flight must not retire the response.
    axi_rd_rq = 1'b1; axi_rd_addr = 32'h0000_0040; axi_rd_valid_ack = 1'b1;
    tick();
    axi_rd_rq = 1'b0;
    repeat (LAT + 1) tick();
    axi_rd_valid_ack = 1'b0;
    tick();
    checks++;
    if (axi_rd_valid !== 1'b1 || axi_rd_data !== d) begin
      errors++; $display("FAIL early_ack_ignored: got v=%b d=%h required v=1 d=%h", axi_rd_valid, axi_rd_data, d);
    end
    axi_rd_valid_ack = 1'b1;
    tick();
    axi_rd_valid_ack = 1'b0;
    exp_rd++;
  endtask

  task automatic test_random();
    logic [31:0] wa;
    logic [31:0] ra;
    for (int n = 0; n < 10; n++) begin
      wa = $urandom;
      write_blk(wa, rand_blk());
      ra = $urandom;
      if (n % 2 == 0) ra[OFFB +: IDXB] = wa[OFFB +: IDXB];
      read_and_check(ra, int'($urandom_range(0, 3)), "rand");
    end
    checks++;
    if (rd_cnt !== exp_cnt(exp_rd) || wr_cnt !== exp_cnt(exp_wr)) begin
      errors++; $display("FAIL rand_cnt: got rd=%0d wr=%0d required %0d %0d", rd_cnt, wr_cnt, exp_cnt(exp_rd), exp_cnt(exp_wr));
    end
  endtask

  task automatic test_overflow();
    logic [31:0] a [5];
    logic [31:0] exp_q [$];
    bit ok;
    bit seen;
    for (int i = 0; i < 4; i++) write_blk({$urandom} << OFFB, rand_blk());
    a[0] = $urandom;
    a[1] = a[0] ^ 32'h8000_0000;   // duplicate block through an aliased address
    a[2] = $urandom;
    a[3] = 32'h0000_0040;
    a[4] = $urandom;
    // Park one response in RESP so the queue fills behind it.
    axi_rd_rq = 1'b1; axi_rd_addr = 32'h0000_0080;
    tick();
    axi_rd_rq = 1'b0;
    ok = 0;
    for (int t = 0; t < 40 && !ok; t++) begin if (axi_rd_valid === 1'b1) ok = 1; else tick(); end
    checks++;
    if (!ok) begin errors++; $display("FAIL ovf_first_valid: got timeout required valid"); end
    for (int i = 0; i < 5; i++) begin
      axi_rd_rq = 1'b1; axi_rd_addr = a[i];
      tick();
      if (i < 4) exp_q.push_back(a[i]);
      if (i == 3) begin
        checks++;
        if (rq_overflow !== 1'b0) begin errors++; $display("FAIL ovf_not_yet: got %b required 0", rq_overflow); end
      end
    end
    axi_rd_rq = 1'b0;
    checks++;
    if (rq_overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b required 1", rq_overflow); end
    axi_rd_valid_ack = 1'b1;
    tick();
    axi_rd_valid_ack = 1'b0;
    exp_rd++;
    for (int k = 0; k < 4; k++) begin
      ok = 0;
      for (int t = 0; t < 40 && !ok; t++) begin if (axi_rd_valid === 1'b1) ok = 1; else tick(); end
      checks++;
      if (!ok) begin errors++; $display("FAIL ovf_resp%0d_valid: got timeout required valid", k); end
      checks++;
      if (axi_rd_valid_addr !== blk_addr(exp_q[k])) begin
        errors++; $display("FAIL ovf_resp%0d_addr: got %h required %h", k, axi_rd_valid_addr, blk_addr(exp_q[k]));
      end
      checks++;
      if (axi_rd_data !== ref_mem[idx_of(exp_q[k])]) begin
        errors++; $display("FAIL ovf_resp%0d_data: got %h required %h", k, axi_rd_data, ref_mem[idx_of(exp_q[k])]);
      end
      axi_rd_valid_ack = 1'b1;
      tick();
      axi_rd_valid_ack = 1'b0;
      exp_rd++;
      checks++;
      if (axi_rd_valid !== 1'b0) begin errors++; $display("FAIL ovf_resp%0d_gap: got %b required 0", k, axi_rd_valid); end
    end
    seen = 0;
    repeat (12) begin tick(); if (axi_rd_valid === 1'b1) seen = 1; end
    checks++;
    if (seen || busy !== 1'b0) begin errors++; $display("FAIL ovf_extra: got extra=%b busy=%b required 0 0", seen, busy); end
    checks++;
    if (rq_overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b required 1", rq_overflow); end
  endtask

  task automatic test_hold();
    logic [BW-1:0] od;
    logic [BW-1:0] nd;
    od = rand_blk();
    nd = ~od;
    write_blk(32'h0000_0080, od);
    axi_rd_rq = 1'b1; axi_rd_addr = 32'h0000_0080;
    tick();
    axi_rd_rq = 1'b0;
    repeat (LAT + 1) tick();
    for (int c = 0; c < 10; c++) begin
      checks++;
      if (axi_rd_valid !== 1'b1 || axi_rd_data !== od || axi_rd_valid_addr !== 32'h0000_0080) begin
        errors++; $display("FAIL hold_c%0d: got v=%b d=%h required v=1 d=%h", c, axi_rd_valid, axi_rd_data, od);
      end
      if (c == 3) begin
        write_blk(32'h0000_0080, nd);
      end else begin
        tick();
      end
    end
    axi_rd_valid_ack = 1'b1;
    tick();
    axi_rd_valid_ack = 1'b0;
    exp_rd++;
    read_and_check(32'h0000_0080, 1, "hold_reread");
  endtask

  task automatic test_write_first();
    logic [BW-1:0] nd;
    write_blk(32'h0000_0080, rand_blk());
    nd = rand_blk();
    axi_rd_rq = 1'b1; axi_rd_addr = 32'h0000_0080;
    tick();
    axi_rd_rq = 1'b0;
    repeat (LAT) tick();
    checks++;
    if (axi_rd_valid !== 1'b0) begin errors++; $display("FAIL wf_pre: got %b required 0", axi_rd_valid); end
    write_blk(32'h4000_0080, nd);   // aliased address, same block, on the capture edge
    checks++;
    if (axi_rd_valid !== 1'b1 || axi_rd_data !== nd) begin
      errors++; $display("FAIL wf_data: got v=%b d=%h required v=1 d=%h", axi_rd_valid, axi_rd_data, nd);
    end
    axi_rd_valid_ack = 1'b1;
    tick();
    axi_rd_valid_ack = 1'b0;
    exp_rd++;
  endtask

  task automatic test_reset_mid();
    bit seen;
    axi_rd_rq = 1'b1; axi_rd_addr = 32'h0000_0040;
    tick();
    axi_rd_rq = 1'b0;
    repeat (2) tick();
    i_rstn = 1'b0;
    #2;
    checks++;
    if (axi_rd_valid !== 1'b0 || busy !== 1'b0 || rd_cnt !== 16'd0 || wr_cnt !== 16'd0) begin
      errors++; $display("FAIL rstwait_now: got v=%b busy=%b rd=%0d wr=%0d required 0", axi_rd_valid, busy, rd_cnt, wr_cnt);
    end
    #1 i_rstn = 1'b1;
    model_reset();
    seen = 0;
    repeat (15) begin tick(); if (axi_rd_valid === 1'b1 || busy === 1'b1) seen = 1; end
    checks++;
    if (seen) begin errors++; $display("FAIL rstwait_ghost: got activity=1 required 0"); end
    // Reset while a response is being presented.
    axi_rd_rq = 1'b1; axi_rd_addr = 32'h0000_0040;
    tick();
    axi_rd_rq = 1'b0;
    repeat (LAT + 2) tick();
    i_rstn = 1'b0;
    #2;
    checks++;
    if (axi_rd_valid !== 1'b0 || axi_rd_data !== '0 || axi_rd_valid_addr !== 32'd0) begin
      errors++; $display("FAIL rstresp_now: got v=%b a=%h required 0 0", axi_rd_valid, axi_rd_valid_addr);
    end
    #1 i_rstn = 1'b1;
    model_reset();
    tick();
    read_and_check(32'h0000_0040, 0, "rst_memclr");
  endtask

  task automatic test_counters();
    i_rstn = 1'b0;
    #2;
    i_rstn = 1'b1;
    model_reset();
    tick();
    write_blk(32'h0000_0100, rand_blk());
    write_blk(32'h0000_0200, rand_blk());
    read_and_check(32'h0000_0100, 0, "cnt_a");
    read_and_check(32'h0000_0200, 2, "cnt_b");
    read_and_check(32'h0000_0300, 0, "cnt_c");
    checks++;
    if (rd_cnt !== exp_cnt(exp_rd)) begin errors++; $display("FAIL cnt_rd: got %0d required %0d", rd_cnt, exp_cnt(exp_rd)); end
    checks++;
    if (wr_cnt !== exp_cnt(exp_wr)) begin errors++; $display("FAIL cnt_wr: got %0d required %0d", wr_cnt, exp_cnt(exp_wr)); end
  endtask

  initial begin
    i_rstn = 1'b0;
    axi_rd_rq = 1'b0; axi_rd_addr = '0; axi_rd_valid_ack = 1'b0;
    axi_wr_rq = 1'b0; axi_wr_addr = '0; axi_wr_data = '0;
    test_reset();
    test_basic();
    test_random();
    test_overflow();
    test_hold();
    test_write_first();
    test_reset_mid();
    test_counters();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
